vga_sync_rx: RTL



---
 rtl/vga_sync_rx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers pixel_x/pixel_y, measures line/frame periods, tracks lock.
// Define VGA_SYNC_RX_POL_AUTO_EN to learn sync polarity from levels seen at each active-video rise.
module vga_sync_rx #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_en_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        locked
);

  localparam logic [11:0] TO_CNT = TIMEOUT[11:0];
  localparam logic [12:0] H_EXP  = H_TOTAL[12:0];
  localparam logic [10:0] V_EXP  = V_TOTAL[10:0];
  localparam logic        HS_ACT = (HS_POL != 0);
  localparam logic        VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (&v) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  logic        r_hs_p1, r_hs_p2, r_vs_p1, r_vs_p2, r_vld_p1, r_vld_p2;
  logic [11:0] r_h_cnt, r_h_meas;
  logic [10:0] r_line_cnt, r_v_meas;
  logic        r_first_hs, r_line_err;
  logic [9:0]  r_pixel_x, r_pixel_y;
  logic        r_pixel_valid, r_frame_start, r_locked;
  state_t      r_state;

  logic        w_hs_pol, w_vs_pol, w_pol_chg;
  logic        w_hs_lead, w_vs_lead, w_de_fall;
  logic [11:0] w_period;
  logic        w_hlen_bad, w_timeout, w_err_set, w_lines_ok;

`ifdef VGA_SYNC_RX_POL_AUTO_EN
  logic r_hs_pol, r_vs_pol;
  logic w_de_rise;

  assign w_de_rise = r_vld_p1 & ~r_vld_p2;

  // Syncs are inactive while video is active, so their level at a de rise is the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_pol <= HS_ACT;
      r_vs_pol <= VS_ACT;
    end else if (w_de_rise) begin
      r_hs_pol <= ~r_hs_p1;
      r_vs_pol <= ~r_vs_p1;
    end
  end

  assign w_hs_pol  = r_hs_pol;
  assign w_vs_pol  = r_vs_pol;
  assign w_pol_chg = w_de_rise & (((~r_hs_p1) != w_hs_pol) | ((~r_vs_p1) != w_vs_pol));
`else
  assign w_hs_pol  = HS_ACT;
  assign w_vs_pol  = VS_ACT;
  assign w_pol_chg = 1'b0;
`endif

  // Stage p1/p2: input synchronisation and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_p1  <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_vs_p2  <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_hs_p1  <= hsync_in;
      r_hs_p2  <= r_hs_p1;
      r_vs_p1  <= vsync_in;
      r_vs_p2  <= r_vs_p1;
      r_vld_p1 <= video_en_in;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign w_hs_lead  = (r_hs_p1 == w_hs_pol) && (r_hs_p2 != w_hs_pol);
  assign w_vs_lead  = (r_vs_p1 == w_vs_pol) && (r_vs_p2 != w_vs_pol);
  assign w_de_fall  = r_vld_p2 & ~r_vld_p1;
  assign w_period   = sat_inc12(r_h_cnt);
  assign w_hlen_bad = (({1'b0, r_h_cnt} + 13'd1) != H_EXP);
  assign w_timeout  = (r_h_cnt == TO_CNT);
  assign w_err_set  = (w_hs_lead & ~r_first_hs & w_hlen_bad) | w_timeout;
  assign w_lines_ok = (r_line_cnt == V_EXP);

  // Measurement counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt    <= '0;
      r_h_meas   <= '0;
      r_line_cnt <= '0;
      r_v_meas   <= '0;
      r_first_hs <= 1'b1;
      r_line_err <= 1'b0;
    end else begin
      if (w_hs_lead) begin
        r_h_meas   <= w_period;
        r_h_cnt    <= '0;
        r_first_hs <= 1'b0;
      end else begin
        r_h_cnt <= sat_inc12(r_h_cnt);
      end
      if (w_vs_lead) begin
        r_v_meas   <= r_line_cnt;
        r_line_cnt <= '0;
      end else if (w_hs_lead) begin
        r_line_cnt <= sat_inc11(r_line_cnt);
      end
      if (w_vs_lead)
        r_line_err <= 1'b0;
      else if (w_err_set)
        r_line_err <= 1'b1;
    end
  end

  // Output stage: aligned with the p2 view of the inputs, two clocks after the pins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_valid <= r_vld_p1;
      r_frame_start <= w_vs_lead;
      if (!r_vld_p1)
        r_pixel_x <= '0;
      else if (r_vld_p2)
        r_pixel_x <= sat_inc10(r_pixel_x);
      else
        r_pixel_x <= '0;
      if (w_vs_lead)
        r_pixel_y <= '0;
      else if (w_de_fall)
        r_pixel_y <= sat_inc10(r_pixel_y);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SEARCH;
      r_locked <= 1'b0;
    end else begin
      r_locked <= (r_state == LOCKED);
      if (w_timeout | w_pol_chg) begin
        r_state <= SEARCH;
      end else begin
        case (r_state)
          SEARCH: if (w_vs_lead) r_state <= VERIFY;
          VERIFY: if (w_vs_lead && !r_line_err && w_lines_ok) r_state <= LOCKED;
          LOCKED: if (w_err_set || (w_vs_lead && !w_lines_ok)) r_state <= SEARCH;
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign pixel_x      = r_pixel_x;
  assign pixel_y      = r_pixel_y;
  assign pixel_valid  = r_pixel_valid;
  assign frame_start  = r_frame_start;
  assign h_total_meas = r_h_meas;
  assign v_total_meas = r_v_meas;
  assign locked       = r_locked;

endmodule
